// File: rtl/ones_enumerator.sv
// Expands a word into the LSB-first list of its set-bit positions, one beat per
// set bit, with a last flag and the frame's total ones count on every beat.
module ones_enumerator #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic [$clog2(DATA_WIDTH)-1:0] dout_idx,
  output logic [$clog2(DATA_WIDTH):0]   dout_count,
  output logic                          dout_empty,
  output logic                          dout_last,
  output logic                          dout_valid,
  input  logic                          dout_ready
);

  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] residual, residual_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic                  zero_flag, zero_next;
  logic                  is_last;
  logic                  beat_xfer;

  function automatic logic [CNT_W-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

  // Scans from the top down so the final hit is the lowest set bit.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [DATA_WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = DATA_WIDTH; i > 0; i--) begin
      if (v[i-1]) begin
        idx = IDX_W'(i - 1);
      end
    end
    return idx;
  endfunction

  always_comb begin
    is_last   = zero_flag ||
                ((residual != '0) && ((residual & (residual - 1'b1)) == '0));
    beat_xfer = (state == EMIT) && dout_ready;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      residual  <= '0;
      count_reg <= '0;
      zero_flag <= 1'b0;
    end else begin
      state     <= state_next;
      residual  <= residual_next;
      count_reg <= count_next;
      zero_flag <= zero_next;
    end
  end

  always_comb begin
    state_next    = state;
    residual_next = residual;
    count_next    = count_reg;
    zero_next     = zero_flag;
    unique case (state)
      IDLE: begin
        if (din_valid) begin
          state_next    = EMIT;
          residual_next = din;
          count_next    = popcount(din);
          zero_next     = (din == '0);
        end
      end
      EMIT: begin
        if (beat_xfer) begin
          if (is_last) begin
            state_next    = IDLE;
            residual_next = '0;
            zero_next     = 1'b0;
          end else begin
            residual_next = residual & (residual - 1'b1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    din_ready  = (state == IDLE);
    dout_valid = 1'b0;
    dout_idx   = '0;
    dout_count = '0;
    dout_empty = 1'b0;
    dout_last  = 1'b0;
    if (state == EMIT) begin
      dout_valid = 1'b1;
      dout_idx   = zero_flag ? '0 : lowest_set(residual);
      dout_count = count_reg;
      dout_empty = zero_flag;
      dout_last  = is_last;
    end
  end

endmodule
